// File: rtl/hwpe_sel_ctrl.sv
// HWPE select controller: drains the active engine, gates its clock, moves the
// select while gated, then re-enables and holds the config bus closed to settle.
module hwpe_sel_ctrl #(
    parameter int N_HWPES         = 2,
    parameter int SEL_W           = (N_HWPES > 1) ? $clog2(N_HWPES) : 1,
    parameter int GATE_CYCLES     = 2,
    parameter int SETTLE_CYCLES   = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_we_i,
    input  logic             ctrl_en_i,
    input  logic [SEL_W-1:0] ctrl_sel_i,
    input  logic             hwpe_busy_i,
    input  logic             periph_req_i,
    input  logic             periph_wen_i,
    input  logic             periph_gnt_i,
    input  logic             periph_r_valid_i,
    output logic             hwpe_en_o,
    output logic [SEL_W-1:0] hwpe_sel_o,
    output logic             periph_stall_o,
    output logic             switching_o,
    output logic             err_o
);
    localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W:0]   SEL_LIM   = (SEL_W + 1)'(N_HWPES);
    localparam logic [OUT_W-1:0] OUT_FULL  = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {S_OFF, S_ON, S_DRAIN, S_GATED, S_SETTLE} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [OUT_W-1:0] r_out;
    logic [SEL_W-1:0] r_sel, w_sel_nxt, r_pend_sel;
    logic             r_pend_vld, r_pend_en, w_pend_clr;
    logic             r_en, r_sw, r_err, w_en_nxt, w_sw_nxt;
    logic             w_wr_bad, w_rd_issue, w_rd_ret, w_out_full, w_pend_on;

    assign w_wr_bad   = ctrl_we_i && ctrl_en_i && ({1'b0, ctrl_sel_i} >= SEL_LIM);
    assign w_rd_issue = periph_req_i && periph_gnt_i && !periph_wen_i;
    assign w_rd_ret   = periph_r_valid_i && (r_out != '0);
    assign w_out_full = (r_out == OUT_FULL);
    assign w_pend_on  = r_pend_vld && r_pend_en;

    // Read-response tracker; a response with nothing in flight is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_out <= '0;
        else if (w_rd_issue && !w_rd_ret && !w_out_full)
            r_out <= r_out + 1'b1;
        else if (!w_rd_issue && w_rd_ret)
            r_out <= r_out - 1'b1;
    end

    // A write landing in the same cycle as a consume wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_vld <= 1'b0;
            r_pend_en  <= 1'b0;
            r_pend_sel <= '0;
        end else if (ctrl_we_i && !w_wr_bad) begin
            r_pend_vld <= 1'b1;
            r_pend_en  <= ctrl_en_i;
            r_pend_sel <= ctrl_sel_i;
        end else if (w_pend_clr) begin
            r_pend_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_en    <= 1'b0;
            r_sw    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_en    <= w_en_nxt;
            r_sw    <= w_sw_nxt;
            r_err   <= w_wr_bad || (periph_r_valid_i && (r_out == '0));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_OFF:    if (w_pend_on) w_state_nxt = S_SETTLE;
            S_ON:     if (r_pend_vld && !(r_pend_en && r_pend_sel == r_sel)) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (!hwpe_busy_i && r_out == '0) w_state_nxt = S_GATED;
            S_GATED:  if (r_cnt == '0) w_state_nxt = w_pend_on ? S_SETTLE : S_OFF;
            S_SETTLE: if (r_cnt == '0) w_state_nxt = S_ON;
            default:  w_state_nxt = S_OFF;
        endcase
    end

    // Select only moves on leaving OFF or GATED, i.e. while the clock is gated.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_sel_nxt  = r_sel;
        w_pend_clr = 1'b0;
        case (r_state)
            S_OFF: begin
                w_pend_clr = r_pend_vld;
                if (w_pend_on) begin
                    w_sel_nxt = r_pend_sel;
                    w_cnt_nxt = SETTLE_LD;
                end
            end
            S_ON:     w_pend_clr = w_pend_on && (r_pend_sel == r_sel);
            S_DRAIN:  if (w_state_nxt == S_GATED) w_cnt_nxt = GATE_LD;
            S_GATED: begin
                if (r_cnt == '0) begin
                    w_pend_clr = 1'b1;
                    if (w_pend_on) begin
                        w_sel_nxt = r_pend_sel;
                        w_cnt_nxt = SETTLE_LD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_SETTLE: if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
            default: ;
        endcase
        w_en_nxt = (w_state_nxt == S_ON) || (w_state_nxt == S_DRAIN) || (w_state_nxt == S_SETTLE);
        w_sw_nxt = (w_state_nxt != S_ON) && (w_state_nxt != S_OFF);
    end

    assign hwpe_en_o      = r_en;
    assign hwpe_sel_o     = r_sel;
    assign switching_o    = r_sw;
    assign err_o          = r_err;
    assign periph_stall_o = (r_state != S_ON) || w_out_full;
endmodule
